odometria: RTL
==============

# odometria

Odometry stage downstream of `avanco` and `orientacao`. It consumes the per-step action code and the current heading, and tracks the robot's grid position inside the pipe map. It also keeps saturating counters for steps taken, turns made and obstructions removed. It raises status flags for return-to-origin, boundary violation and stuck-turning; `LMapa` and the bench read these flags.

## Interface
- `MAP_W`, 16: map width in cells; x range 0..MAP_W-1.
- `MAP_H`, 16: map height in cells; y range 0..MAP_H-1.
- `X0`, 0: start x coordinate; reset value of `pos_x`.
- `Y0`, 0: start y coordinate; reset value of `pos_y`.
- `CW`, 8: width of the step, turn and removal counters.
- `GIRO_MAX`, 4: number of consecutive turns without an advance that flags stuck.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: sample strobe, one `clock` cycle wide, asserted once per robot step.
- `acao` in 3: action code. 0 NADA, 1 AVANCAR, 2 GIRAR, 3 REMOVER; 4..7 are treated as NADA.
- `orientacao` in 3: heading. 0 NORTE (y+1), 1 LESTE (x+1), 2 SUL (y−1), 3 OESTE (x−1); 4..7 are treated as no move.
- `pos_x` out $clog2(MAP_W): current x.
- `pos_y` out $clog2(MAP_H): current y.
- `passos` out CW: accepted advances, saturating.
- `giros` out CW: turns, saturating.
- `removidos` out CW: removals, saturating.
- `estado` out 2: FSM state.
- `na_origem` out 1: one-cycle pulse on return to the start cell.
- `fora_limite` out 1: sticky; set by an attempted move off the map.
- `travado` out 1: sticky; set on reaching GIRO_MAX consecutive turns.
- `fim` out 1: level; high while in state FIM.

## Operation
- All inputs are sampled only on cycles where `en`=1. When `en`=0 every register holds, except `na_origem`, which clears.
- FSM states: OCIOSO (0), ATIVO (1), FIM (2). Encoding 3 is unused and recovers to OCIOSO.
- OCIOSO → ATIVO on the first accepted AVANCAR.
- ATIVO → FIM when an accepted AVANCAR lands on (X0, Y0).
- FIM is terminal until `reset`. In FIM, actions are still counted but the position is frozen.
- AVANCAR:
  - Compute the target cell from `orientacao`.
  - If the target is out of range (x<0, x≥MAP_W, y<0 or y≥MAP_H): position holds, `fora_limite` sets, `passos` does not increment.
  - Otherwise: update the position, increment `passos`, and clear the turn-run counter.
- GIRAR: increment `giros` and the turn-run counter. When the turn-run counter reaches GIRO_MAX, `travado` sets. The turn-run counter saturates at GIRO_MAX.
- REMOVER: increment `removidos`. The turn-run counter is unaffected.
- NADA and invalid codes: no effect.
- `na_origem` pulses together with the ATIVO→FIM transition, i.e. in the same cycle as the updated position.
- Arithmetic: position is computed with one extra bit to detect underflow and overflow. Counters stop at 2^CW−1 and never wrap.

## Timing
- Latency is 1 cycle: every output is registered and reflects the `en` sample from the previous rising edge.
- Reset values: `pos_x`=X0, `pos_y`=Y0, all counters 0, `estado`=OCIOSO, all flags 0.
- Reset assertion mid-operation clears state immediately, asynchronously. Deassertion takes effect at the next `clock` edge.
- Only one action is possible per sample, so simultaneous-event conflicts cannot occur.
- If `en` is held high, the block samples every cycle.

## Structure
- `robo_pkg` holds:
  - `acao_t` with NADA/AVANCAR/GIRAR/REMOVER;
  - `orient_t` with NORTE/LESTE/SUL/OESTE;
  - `estado_t` with OCIOSO/ATIVO/FIM;
  - the code-width constant, 3.
- One sub-module, `contador_sat`: parameter width, with clock, active-low async reset, `inc` input and saturating output. It is instantiated three times for `passos`, `giros` and `removidos`.

## Test plan
- Reset, then strobe AVANCAR with LESTE ×3 → `pos_x`=3, `pos_y`=0, `passos`=3, `estado`=ATIVO.
- From (0,0), strobe AVANCAR with SUL → position stays (0,0), `fora_limite`=1, `passos` unchanged, `estado` stays OCIOSO.
- Route LESTE, NORTE, OESTE, SUL → back at (0,0): `na_origem` pulses for 1 cycle, `estado`=FIM, `fim`=1. A further AVANCAR with LESTE leaves the position at (0,0).
- GIRAR ×3, then AVANCAR, then GIRAR ×4 → `travado` sets only on the 4th turn of the second run, and `giros`=7.
- CW=2: REMOVER ×5 → `removidos`=3, held at saturation.
- Assert `reset` low mid-route at (2,1) → all outputs return to reset values within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/robo_pkg.sv
// robo_pkg: shared action, heading and state encodings for the robot pipeline.
package robo_pkg;
   localparam int CODE_W = 3;
   typedef enum logic [CODE_W-1:0] {NADA, AVANCAR, GIRAR, REMOVER} acao_t;
   typedef enum logic [CODE_W-1:0] {NORTE, LESTE, SUL, OESTE} orient_t;
   typedef enum logic [1:0] {OCIOSO, ATIVO, FIM} estado_t;
endpackage

// File: rtl/odometria_if.sv
// odometria_if: step strobe/action/heading in, position, counters and flags out.
interface odometria_if #(parameter int MAP_W = 16, parameter int MAP_H = 16, parameter int CW = 8);
   import robo_pkg::*;
   logic                     en;
   logic [CODE_W-1:0]        acao;
   logic [CODE_W-1:0]        orientacao;
   logic [$clog2(MAP_W)-1:0] pos_x;
   logic [$clog2(MAP_H)-1:0] pos_y;
   logic [CW-1:0]            passos;
   logic [CW-1:0]            giros;
   logic [CW-1:0]            removidos;
   logic [1:0]               estado;
   logic                     na_origem;
   logic                     fora_limite;
   logic                     travado;
   logic                     fim;
   modport master (output en, acao, orientacao,
                   input pos_x, pos_y, passos, giros, removidos, estado, na_origem, fora_limite, travado, fim);
   modport slave  (input en, acao, orientacao,
                   output pos_x, pos_y, passos, giros, removidos, estado, na_origem, fora_limite, travado, fim);
endinterface

// File: rtl/contador_sat.sv
// contador_sat: up-counter that stops at all-ones instead of wrapping.
module contador_sat #(parameter int WIDTH = 8) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);
   logic [WIDTH-1:0] r_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
   assign o_cnt = r_cnt;
endmodule

// File: rtl/odometria.sv
// odometria: tracks grid position from action/heading strobes, counts steps,
// turns and removals, and flags return-to-origin, off-map moves and stuck turning.
module odometria
   import robo_pkg::*;
#(
   parameter int MAP_W    = 16,
   parameter int MAP_H    = 16,
   parameter int X0       = 0,
   parameter int Y0       = 0,
   parameter int CW       = 8,
   parameter int GIRO_MAX = 4
) (
   input logic        clock,
   input logic        reset,
   odometria_if.slave bus
);
   localparam int XW = $clog2(MAP_W);
   localparam int YW = $clog2(MAP_H);
   localparam int RW = $clog2(GIRO_MAX + 1);

   estado_t       r_estado;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [RW-1:0] r_run;
   logic          r_na, r_fora, r_trav, r_fim;
   logic [XW:0]   w_tx;
   logic [YW:0]   w_ty;
   logic          w_av, w_gir, w_rem, w_dentro, w_adv, w_origem;

   // one spare bit: decrement below zero wraps to all-ones, which fails the range check
   always_comb begin
      w_tx     = bus.orientacao == LESTE ? {1'b0, r_x} + 1'b1 :
                 bus.orientacao == OESTE ? {1'b0, r_x} - 1'b1 : {1'b0, r_x};
      w_ty     = bus.orientacao == NORTE ? {1'b0, r_y} + 1'b1 :
                 bus.orientacao == SUL   ? {1'b0, r_y} - 1'b1 : {1'b0, r_y};
      w_av     = bus.en && bus.acao == AVANCAR;
      w_gir    = bus.en && bus.acao == GIRAR;
      w_rem    = bus.en && bus.acao == REMOVER;
      w_dentro = w_tx < (XW+1)'(MAP_W) && w_ty < (YW+1)'(MAP_H);
      w_adv    = w_av && !bus.orientacao[2] && w_dentro;
      w_origem = w_tx == (XW+1)'(X0) && w_ty == (YW+1)'(Y0);
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         r_estado <= OCIOSO;
         r_x      <= XW'(X0);
         r_y      <= YW'(Y0);
         r_run    <= '0;
         r_na     <= 1'b0;
         r_fora   <= 1'b0;
         r_trav   <= 1'b0;
         r_fim    <= 1'b0;
      end else begin
         r_na <= 1'b0;
         if (bus.en) begin
            if (w_adv && r_estado != FIM) begin
               r_x <= w_tx[XW-1:0];
               r_y <= w_ty[YW-1:0];
            end
            if (w_av && !w_dentro) r_fora <= 1'b1;
            if (w_adv) r_run <= '0;
            else if (w_gir && r_run != RW'(GIRO_MAX)) begin
               r_run <= r_run + 1'b1;
               if (r_run == RW'(GIRO_MAX - 1)) r_trav <= 1'b1;
            end
            case (r_estado)
               OCIOSO: if (w_adv) r_estado <= ATIVO;
               ATIVO:  if (w_adv && w_origem) begin
                  r_estado <= FIM;
                  r_na     <= 1'b1;
                  r_fim    <= 1'b1;
               end
               FIM:    r_estado <= FIM;
               default: r_estado <= OCIOSO;
            endcase
         end
      end

   contador_sat #(.WIDTH(CW)) u_passos    (.i_clk(clock), .i_rst_n(reset), .i_inc(w_adv), .o_cnt(bus.passos));
   contador_sat #(.WIDTH(CW)) u_giros     (.i_clk(clock), .i_rst_n(reset), .i_inc(w_gir), .o_cnt(bus.giros));
   contador_sat #(.WIDTH(CW)) u_removidos (.i_clk(clock), .i_rst_n(reset), .i_inc(w_rem), .o_cnt(bus.removidos));

   assign bus.pos_x       = r_x;
   assign bus.pos_y       = r_y;
   assign bus.estado      = r_estado;
   assign bus.na_origem   = r_na;
   assign bus.fora_limite = r_fora;
   assign bus.travado     = r_trav;
   assign bus.fim         = r_fim;
endmodule
